// File: rtl/gain_pkg.sv
// Shared constants for the output gain stage: Q2.6 gain table, datapath widths
// and the saturation helper used on the scaled product.
package gain_pkg;

   localparam int SAMPLE_W       = 16;
   localparam int GAIN_W         = 8;
   localparam int GAIN_FRAC_BITS = 6;
   localparam int PROD_W         = 25;

   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7fff;
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

   localparam logic signed [PROD_W-1:0] PROD_SAT_MAX = {{(PROD_W-SAMPLE_W){1'b0}}, SAMPLE_MAX};
   localparam logic signed [PROD_W-1:0] PROD_SAT_MIN = {{(PROD_W-SAMPLE_W){1'b1}}, SAMPLE_MIN};

   // -12 dB .. +9 dB in 3 dB steps, 64 = unity
   localparam logic [GAIN_W-1:0] GAIN_TABLE [8] = '{
      8'd16, 8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd181
   };

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] sample;
      logic                       ovf;
   } sat_t;

   function automatic sat_t sat_sample(input logic signed [PROD_W-1:0] q);
      sat_t s;
      s.ovf    = 1'b1;
      s.sample = q[SAMPLE_W-1:0];
      if (q > PROD_SAT_MAX) begin
         s.sample = SAMPLE_MAX;
      end else if (q < PROD_SAT_MIN) begin
         s.sample = SAMPLE_MIN;
      end else begin
         s.ovf = 1'b0;
      end
      return s;
   endfunction

endpackage

// File: rtl/gain_ramp.sv
// De-zipper ramp: curGain moves 1 LSB toward target every RAMP_DIV samples.
// Zero-latency compare for ramping; no backpressure, free-running divider.
module gain_ramp
   import gain_pkg::*;
#(
   parameter int RAMP_DIV = 48
) (
   input  logic              clk_48,
   input  logic              reset,
   input  logic [GAIN_W-1:0] target,
   output logic [GAIN_W-1:0] curGain,
   output logic              ramping
);

   localparam int               DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick    = (div_cnt == DIV_LAST);
   assign ramping = (curGain != target);

   // Divider is never restarted by target changes, so a new target takes
   // effect on whichever tick comes next.
   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         curGain <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            if (curGain < target) begin
               curGain <= curGain + 1'b1;
            end else if (curGain > target) begin
               curGain <= curGain - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gain_stage.sv
// Output volume stage: ramped gain multiply, floor shift, saturate, held clip flag.
// Latency 2 cycles gainIn->gainOut; no backpressure, one sample per clk_48.
module gain_stage
   import gain_pkg::*;
#(
   parameter int RAMP_DIV  = 48,
   parameter int CLIP_HOLD = 24000
) (
   input  logic                       clk_48,
   input  logic                       reset,
   input  logic [2:0]                 gainSelect,
   input  logic                       mute,
   input  logic signed [SAMPLE_W-1:0] gainIn,
   output logic signed [SAMPLE_W-1:0] gainOut,
   output logic [GAIN_W-1:0]          curGain,
   output logic                       clip,
   output logic                       ramping
);

   localparam int                CLIP_W    = $clog2(CLIP_HOLD + 1);
   localparam logic [CLIP_W-1:0] CLIP_LOAD = CLIP_W'(CLIP_HOLD);

   logic [GAIN_W-1:0]        target;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] prod_sh;
   sat_t                     sat;
   logic [CLIP_W-1:0]        clip_cnt;

   assign target = mute ? '0 : GAIN_TABLE[gainSelect];

   gain_ramp #(
      .RAMP_DIV (RAMP_DIV)
   ) u_ramp (
      .clk_48  (clk_48),
      .reset   (reset),
      .target  (target),
      .curGain (curGain),
      .ramping (ramping)
   );

   // Arithmetic shift floors toward -inf, so small negative inputs round away from zero.
   assign prod_sh = prod >>> GAIN_FRAC_BITS;
   assign sat     = sat_sample(prod_sh);
   assign clip    = (clip_cnt != '0);

   always_ff @(posedge clk_48 or posedge reset) begin
      if (reset) begin
         prod     <= '0;
         gainOut  <= '0;
         clip_cnt <= '0;
      end else begin
         prod    <= PROD_W'(gainIn) * PROD_W'($signed({1'b0, curGain}));
         gainOut <= sat.sample;
         if (sat.ovf) begin
            clip_cnt <= CLIP_LOAD;
         end else if (clip_cnt != '0) begin
            clip_cnt <= clip_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gain_stage.sv
// Randomized scoreboard bench for gain_stage with a cycle-level arithmetic reference model.
module tb_gain_stage;

   localparam int RD = 4;
   localparam int CH = 8;
   localparam int TBL [8] = '{16, 23, 32, 45, 64, 90, 128, 181};

   logic               clk_48 = 1'b0;
   logic               reset;
   logic [2:0]         gainSelect;
   logic               mute;
   logic signed [15:0] gainIn;
   logic signed [15:0] gainOut;
   logic [7:0]         curGain;
   logic               clip;
   logic               ramping;

   gain_stage #(
      .RAMP_DIV  (RD),
      .CLIP_HOLD (CH)
   ) dut (
      .clk_48     (clk_48),
      .reset      (reset),
      .gainSelect (gainSelect),
      .mute       (mute),
      .gainIn     (gainIn),
      .gainOut    (gainOut),
      .curGain    (curGain),
      .clip       (clip),
      .ramping    (ramping)
   );

   always #5 clk_48 = ~clk_48;

   typedef struct {
      int due;
      int out;
      bit cl;
      int g;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   edge_cnt = 0;
   int   checks   = 0;
   int   failures = 0;

   // reference model state
   int m_g;
   int m_n;
   int m_pend;
   bit m_pend_sat;
   int m_last_sat;

   always @(posedge clk_48) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
      end
   endtask

   function automatic int target_of(input int sel, input bit mu);
      return mu ? 0 : TBL[sel];
   endfunction

   // out = clamp(floor(x * g / 64))
   function automatic int scaled(input int x, input int g, output bit ovf);
      int p;
      int q;
      p   = x * g;
      q   = (p >= 0) ? p / 64 : -((-p + 63) / 64);
      ovf = (q > 32767) || (q < -32768);
      if (q > 32767)       q = 32767;
      else if (q < -32768) q = -32768;
      return q;
   endfunction

   function automatic int rnd_in();
      logic signed [15:0] r;
      if ($urandom_range(0, 3) == 0) begin
         r = 16'($urandom);
         return int'(r);
      end
      return int'($urandom_range(0, 4000)) - 2000;
   endfunction

   always @(negedge clk_48) begin
      while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         mon_e = sb.pop_front();
         chk("gainOut", int'(gainOut), mon_e.out);
         chk("clip", int'(clip), int'(mon_e.cl));
         chk("curGain", int'(curGain), mon_e.g);
         chk("ramping", int'(ramping), int'(mon_e.g != target_of(int'(gainSelect), mute)));
      end
   end

   // Drive one sample, advance the model across the coming edge, queue the expectation.
   task automatic step(input int sel, input bit mu, input int x);
      int   tgt;
      int   out_now;
      bit   ovf_now;
      exp_t e;
      gainSelect = 3'(sel);
      mute       = mu;
      gainIn     = 16'(x);
      tgt        = target_of(sel, mu);
      out_now    = m_pend;
      ovf_now    = m_pend_sat;
      m_pend     = scaled(x, m_g, m_pend_sat);
      m_n++;
      if (m_n % RD == 0) begin
         if (m_g < tgt)      m_g++;
         else if (m_g > tgt) m_g--;
      end
      if (ovf_now) m_last_sat = m_n;
      e.due = edge_cnt + 1;
      e.out = out_now;
      e.cl  = (m_n - m_last_sat) < CH;
      e.g   = m_g;
      sb.push_back(e);
      @(posedge clk_48);
      #1;
   endtask

   // Assert reset between edges, check outputs clear at once, hold 3 edges, release mid-cycle.
   task automatic do_reset(input int sel, input bit mu);
      gainSelect = 3'(sel);
      mute       = mu;
      #2 reset = 1'b1;
      #1;
      sb.delete();
      chk("rst_gainOut", int'(gainOut), 0);
      chk("rst_curGain", int'(curGain), 0);
      chk("rst_clip", int'(clip), 0);
      chk("rst_ramping", int'(ramping), int'(target_of(sel, mu) != 0));
      m_g        = 0;
      m_n        = 0;
      m_pend     = 0;
      m_pend_sat = 1'b0;
      m_last_sat = -1000000;
      repeat (3) @(posedge clk_48);
      #2 reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      gainSelect = 3'd4;
      mute       = 1'b0;
      gainIn     = '0;
      do_reset(4, 0);

      for (int i = 0; i < 255; i++) step(4, 0, rnd_in());
      chk("soft_start_63", int'(curGain), 63);
      step(4, 0, rnd_in());
      chk("soft_start_64", int'(curGain), 64);
      chk("soft_start_ramping", int'(ramping), 0);
      for (int i = 0; i < 8; i++) step(4, 0, rnd_in());
      chk("hold_64", int'(curGain), 64);

      step(4, 0, 1000);
      step(4, 0, -1);
      step(4, 0, 32767);
      step(4, 0, -32768);
      for (int i = 0; i < 4; i++) step(4, 0, rnd_in());

      for (int i = 0; i < 140; i++) step(2, 0, rnd_in());
      chk("gain_32", int'(curGain), 32);
      step(2, 0, -3);
      step(2, 0, 3);
      step(2, 0, -1);
      step(2, 0, 1);
      for (int i = 0; i < 4; i++) step(2, 0, rnd_in());

      for (int i = 0; i < 100 && m_g != 40; i++) step(5, 0, rnd_in());
      for (int i = 0; i < 180; i++) step(5, 1, rnd_in());
      chk("mute_gain0", int'(curGain), 0);

      for (int i = 0; i < 400 && m_g != 70; i++) step(6, 0, rnd_in());
      for (int i = 0; i < 200; i++) step(2, 0, rnd_in());
      chk("reverse_settle", int'(curGain), 32);

      for (int i = 0; i < 620; i++) step(7, 0, rnd_in());
      chk("gain_181", int'(curGain), 181);
      step(7, 0, 32767);
      step(7, 0, -32768);
      step(7, 0, 32767);
      for (int i = 0; i < 12; i++) step(7, 0, 100);
      chk("clip_released", int'(clip), 0);

      for (int i = 0; i < 6; i++) step(0, 0, 32767);
      do_reset(4, 0);
      for (int i = 0; i < 256; i++) step(4, 0, rnd_in());
      chk("restart_64", int'(curGain), 64);
      step(4, 0, 0);
      step(4, 0, 0);

      @(negedge clk_48);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gain_stage.md
Name: gain_stage

Overview:
Output volume stage sitting directly downstream of the highpass filter and upstream of outputLevel. It consumes one signed 16-bit sample per clk_48 cycle and applies a selectable gain with a de-zippered (ramped) gain change. Results are saturated, and a held clip indication is driven for the front-panel display. A mute input ramps the gain to zero instead of cutting it instantly.

Parameters:
RAMP_DIV, 48, samples between successive 1-LSB gain steps (min 1)
CLIP_HOLD, 24000, samples the clip flag stays high after the last saturating sample (min 1)

Ports:
clk_48  in  1  sample clock; one sample per rising edge
reset  in  1  asynchronous, active-high reset
gainSelect  in  3  index into gain table
mute  in  1  1 = ramp gain toward 0
gainIn  in  16  signed input sample (highpassOut)
gainOut  out  16  signed output sample (to outputLevel outWave)
curGain  out  8  current applied gain, unsigned Q2.6
clip  out  1  high while the clip hold counter is nonzero
ramping  out  1  high while curGain != target

Behaviour:
- Gain table (Q2.6, gainSelect 0..7): 16, 23, 32, 45, 64, 90, 128, 181 (-12 to +9 dB, 3 dB steps; 64 = unity).
- target = mute ? 0 : table[gainSelect]. Combinational, re-evaluated every cycle.
- Ramp divider:
  - Free-running counter 0..RAMP_DIV-1; it is not restarted by target changes.
  - At terminal count: if curGain < target, curGain += 1; if curGain > target, curGain -= 1; else hold.
  - curGain never overshoots target.
- ramping = (curGain != target), combinational from registers/inputs.
- Datapath, latency exactly 2 cycles from gainIn to gainOut:
  - Stage 1: prod <= signed(gainIn) * unsigned(curGain), 25-bit signed. curGain is sampled in the same cycle as gainIn.
  - Stage 2: q = prod >>> 6 (arithmetic shift, floor toward -inf). Saturate q to [-32768, 32767]; gainOut <= sat(q).
- Clip counter:
  - When stage 2 saturates, the counter loads CLIP_HOLD on the same edge that gainOut registers the saturated value; otherwise it decrements if nonzero.
  - clip = (counter != 0), so clip rises together with the first saturated gainOut.
  - Back-to-back saturating samples keep reloading the counter.
  - clip falls CLIP_HOLD cycles after the last saturated output.
- Reset (asynchronous, any time, including mid-ramp):
  - Clears to 0: gainOut, both pipeline registers, curGain, divider, clip counter.
  - Hence clip = 0, and ramping = (target != 0).
  - After release, curGain soft-starts from 0 toward target.
- gainSelect or mute change mid-ramp: direction follows the new target at the next divider tick; there is no reset of ramp state.
- mute = 1 with curGain = 0: output is exactly 0 two cycles after the gain reaches 0.

Decomposition:
- Package gain_pkg: GAIN_TABLE[8] (8-bit Q2.6 constants), GAIN_FRAC_BITS = 6, SAMPLE_W = 16, GAIN_W = 8, PROD_W = 25, SAMPLE_MAX / SAMPLE_MIN constants.
- One sub-module, gain_ramp:
  - Contains the divider counter, curGain register, and target compare.
  - Ports: clk_48, reset, target, curGain, ramping.
- gain_stage holds the multiply/shift/saturate pipeline and the clip hold counter.

Test Plan:
All tests use RAMP_DIV=4 and CLIP_HOLD=8.
- Soft start: reset high 3 cycles with gainSelect=4, mute=0, then release -> curGain steps 0,1,2,... once per 4 cycles, reaches 64 after 256 cycles, then ramping=0 and curGain holds at 64.
- Arithmetic at steady gain:
  - curGain=64, gainIn=1000 -> gainOut=1000 exactly 2 cycles later.
  - gainIn=-1 -> -1.
  - curGain=32, gainIn=-3 -> -2 (floor); gainIn=3 -> 1.
- Saturation and hold:
  - curGain=181, gainIn=32767 -> gainOut=32767 with clip=1 on the same edge.
  - gainIn=-32768 -> -32768.
  - Input returned to 100 -> clip falls exactly 8 cycles after the last saturated output.
- Mute mid-ramp: assert mute while curGain=40 and rising -> curGain falls 1 per 4 cycles to 0, and gainOut=0 two cycles later. Deassert -> curGain ramps back to table[gainSelect].
- Direction reversal: ramping up toward 128 at curGain=70, gainSelect changed to 2 -> curGain decreases at the next tick and settles at 32 with no overshoot.
- Async reset mid-operation: assert reset between clock edges during saturation and ramp -> gainOut, curGain and clip are 0 immediately, without waiting for a clock edge. After release, the soft start repeats.
